// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared types and constants for the uart_tx arbiter.
//   uta_state_e : arbiter FSM states (IDLE, ISSUE, WAIT_DONE).
//   CNT_W       : width of the ISSUE timeout counter (covers BUSY_TIMEOUT up to 65535).
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    UTA_IDLE  = 2'd0,
    UTA_ISSUE = 2'd1,
    UTA_WAIT  = 2'd2
  } uta_state_e;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans ptr+1 .. ptr (mod N) and selects the
//   first asserted request. Generic so a future bus arbiter can reuse it.
//   req   in  N    request vector
//   ptr   in  IW   index of the most recent winner
//   grant out N    one-hot winner (0 when nothing requested)
//   idx   out IW   binary index of the winner (0 when nothing requested)
//   found out 1    at least one request is asserted
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Rotating priority scan; the first hit after ptr wins and masks later hits.
  always_comb begin
    int unsigned   pos;
    logic          hit;
    logic [IW-1:0] sel;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    hit   = 1'b0;
    sel   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      pos        = (32'(ptr) + i) % N;
      sel        = IW'(pos);
      hit        = req[sel] & ~found;
      grant[sel] = grant[sel] | hit;
      idx        = hit ? sel : idx;
      found      = found | hit;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx transmitter among NUM_REQ byte requesters with round-robin
//   grants. The granted byte is latched and held on tx_byte_o until the frame ends.
//   clk_i        in   1          system clock
//   rst_ni       in   1          asynchronous active-low reset
//   req_valid_i  in   NUM_REQ    requester k has a byte pending
//   req_byte_i   in   8*NUM_REQ  byte of requester k at [8k+7:8k]
//   req_ready_o  out  NUM_REQ    one-cycle one-hot accept pulse
//   tx_byte_o    out  8          byte to uart_tx
//   tx_en_o      out  1          enable to uart_tx
//   tx_ready_i   in   1          uart_tx idle indication
//   grant_o      out  NUM_REQ    one-hot owner of the in-flight byte
//   busy_o       out  1          arbiter not idle
//   timeout_o    out  1          sticky: transmitter never went busy after an enable
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_byte_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [7:0]             tx_byte_o,
  output logic                   tx_en_o,
  input  logic                   tx_ready_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int unsigned      IW       = $clog2(NUM_REQ);
  localparam logic [IW-1:0]    PTR_RST  = IW'(NUM_REQ - 1);
  // The counter is compared against BUSY_TIMEOUT-1 so tx_en_o is high for
  // exactly BUSY_TIMEOUT cycles when the transmitter never responds.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  uta_state_e       state_r;
  logic [IW-1:0]    rr_ptr_r;
  logic [CNT_W-1:0] cnt_r;

  logic [NUM_REQ-1:0] pick_grant_s;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_found_s;
  logic [7:0]         pick_byte_s;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  assign pick_byte_s = req_byte_i[{pick_idx_s, 3'b000} +: 8];

  // Arbiter FSM with registered outputs, pointer and saturating timeout counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= UTA_IDLE;
      rr_ptr_r    <= PTR_RST;
      cnt_r       <= '0;
      req_ready_o <= '0;
      tx_byte_o   <= 8'h00;
      tx_en_o     <= 1'b0;
      grant_o     <= '0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      // Accept pulse lasts a single cycle.
      req_ready_o <= '0;
      case (state_r)
        UTA_IDLE: begin
          if (pick_found_s && tx_ready_i) begin
            tx_byte_o   <= pick_byte_s;
            grant_o     <= pick_grant_s;
            req_ready_o <= pick_grant_s;
            rr_ptr_r    <= pick_idx_s;
            cnt_r       <= '0;
            tx_en_o     <= 1'b1;
            busy_o      <= 1'b1;
            state_r     <= UTA_ISSUE;
          end else begin
            state_r <= UTA_IDLE;
          end
        end
        UTA_ISSUE: begin
          // A falling ready wins over a timeout on the same cycle.
          if (!tx_ready_i) begin
            tx_en_o <= 1'b0;
            state_r <= UTA_WAIT;
          end else if (cnt_r >= CNT_LAST) begin
            tx_en_o   <= 1'b0;
            timeout_o <= 1'b1;
            grant_o   <= '0;
            busy_o    <= 1'b0;
            state_r   <= UTA_IDLE;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + 16'd1;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        UTA_WAIT: begin
          if (tx_ready_i) begin
            grant_o <= '0;
            busy_o  <= 1'b0;
            state_r <= UTA_IDLE;
          end else begin
            state_r <= UTA_WAIT;
          end
        end
        default: begin
          tx_en_o <= 1'b0;
          grant_o <= '0;
          busy_o  <= 1'b0;
          state_r <= UTA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (NUM_REQ=2, BUSY_TIMEOUT=4) with a stub
//   uart_tx, a transaction-level reference model checked every cycle, a table of
//   grant vectors, hand-written corner-case sequences and a randomized phase.
module tb_uart_tx_arbiter;
  localparam int N  = 2;
  localparam int BT = 4;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_byte = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_byte;
  logic           tx_en;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_byte_i  (req_byte),
    .req_ready_o (req_ready),
    .tx_byte_o   (tx_byte),
    .tx_en_o     (tx_en),
    .tx_ready_i  (tx_ready),
    .grant_o     (grant),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  // Stub uart_tx: ready falls one cycle after enable and stays low 10 cycles.
  logic stub_ready;
  int   stub_cnt;
  logic stub_dead  = 1'b0;
  logic force_busy = 1'b0;
  assign tx_ready = stub_ready & ~force_busy;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stub_ready <= 1'b1;
      stub_cnt   <= 0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_ready <= 1'b1;
    end else if (tx_en && stub_ready && !stub_dead) begin
      stub_ready <= 1'b0;
      stub_cnt   <= 10;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction view of the arbiter, advanced once per cycle.
  int             m_phase;     // 0 idle, 1 enable asserted, 2 frame in progress
  logic           m_en;
  logic [7:0]     m_byte;
  logic [N-1:0]   m_grant;
  logic [N-1:0]   m_ready;
  logic           m_to;
  int             m_last;      // last winner
  int             m_en_cycles; // cycles tx_en has been high for this byte

  always @(negedge clk) begin
    int w;
    if (!rst_ni) begin
      m_phase = 0; m_en = 1'b0; m_byte = 8'h00; m_grant = '0; m_ready = '0;
      m_to = 1'b0; m_last = N - 1; m_en_cycles = 0;
    end
    check("model", 32'({tx_en, tx_byte, grant, req_ready, busy, timeout}),
          32'({m_en, m_byte, m_grant, m_ready, (m_phase != 0), m_to}));
    if (rst_ni) begin
      m_ready = '0;
      if (m_phase == 0) begin
        if (req_valid != '0 && tx_ready) begin
          w = -1;
          for (int i = 1; i <= N; i++)
            if (w < 0 && req_valid[(m_last + i) % N]) w = (m_last + i) % N;
          m_byte = req_byte[8*w +: 8];
          m_grant = '0; m_grant[w] = 1'b1;
          m_ready = m_grant;
          m_last = w;
          m_en = 1'b1; m_en_cycles = 1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!tx_ready) begin
          m_en = 1'b0; m_phase = 2;
        end else if (m_en_cycles == BT) begin
          m_en = 1'b0; m_to = 1'b1; m_grant = '0; m_phase = 0;
        end else begin
          m_en_cycles++;
        end
      end else begin
        if (tx_ready) begin
          m_grant = '0; m_phase = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int bound, output int idx);
    idx = -1;
    for (int n = 0; n < bound; n++) begin
      tick();
      if (req_ready != '0) break;
    end
    check("accept_seen", 32'(req_ready != '0), 32'd1);
    for (int k = 0; k < N; k++)
      if (req_ready[k]) idx = k;
  endtask

  task automatic wait_idle(input int bound, output int cycles);
    cycles = 0;
    while (busy && cycles < bound) begin
      tick();
      cycles++;
    end
    check("idle_seen", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [7:0]   b0;
    logic [7:0]   b1;
    int           exp_idx;
    logic [7:0]   exp_byte;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] cont_bytes[4];

  initial begin
    int idx, cyc, n_en;

    vecs[0] = '{2'b11, 8'h10, 8'h20, 1, 8'h20};
    vecs[1] = '{2'b01, 8'hA5, 8'h00, 0, 8'hA5};
    vecs[2] = '{2'b11, 8'h3C, 8'hC3, 1, 8'hC3};
    vecs[3] = '{2'b11, 8'h01, 8'h02, 0, 8'h01};
    vecs[4] = '{2'b10, 8'h00, 8'h7E, 1, 8'h7E};
    vecs[5] = '{2'b10, 8'h00, 8'h81, 1, 8'h81};
    vecs[6] = '{2'b01, 8'hFF, 8'h00, 0, 8'hFF};
    vecs[7] = '{2'b11, 8'h5A, 8'hA5, 1, 8'hA5};
    cont_bytes = '{8'h10, 8'h20, 8'h10, 8'h20};

    // Reset state
    tick(); tick();
    check("reset_outputs", 32'({tx_en, tx_byte, grant, req_ready, busy, timeout}), 32'd0);
    rst_ni = 1'b1;
    tick();

    // Single requester
    req_valid = 2'b01; req_byte = 16'h0041;
    tick();
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_en", 32'(tx_en), 32'h1);
    check("single_byte", 32'(tx_byte), 32'h41);
    req_valid = '0;
    tick();
    check("single_ready_pulse", 32'(req_ready), 32'h0);
    wait_idle(40, cyc);
    check("single_turnaround", 32'(cyc + 1), 32'd12);

    // Table-driven grant vectors
    for (int v = 0; v < 8; v++) begin
      req_valid = vecs[v].valid;
      req_byte  = {vecs[v].b1, vecs[v].b0};
      wait_accept(10, idx);
      check($sformatf("vec%0d_idx", v), 32'(idx), 32'(vecs[v].exp_idx));
      check($sformatf("vec%0d_byte", v), 32'(tx_byte), 32'(vecs[v].exp_byte));
      req_valid = '0;
      wait_idle(40, cyc);
    end

    // Contention with both requesters held
    req_valid = 2'b11; req_byte = 16'h2010;
    for (int g = 0; g < 4; g++) begin
      wait_accept(40, idx);
      check($sformatf("cont%0d_idx", g), 32'(idx), 32'(g % 2));
      check($sformatf("cont%0d_byte", g), 32'(tx_byte), 32'(cont_bytes[g]));
    end
    req_valid = '0;
    wait_idle(40, cyc);

    // Transmitter busy holds off acceptance
    force_busy = 1'b1;
    req_valid = 2'b01; req_byte = 16'h0077;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("busy_no_accept", 32'({req_ready, busy}), 32'd0);
    end
    force_busy = 1'b0;
    tick();
    check("busy_then_accept", 32'(req_ready), 32'h1);
    check("busy_then_byte", 32'(tx_byte), 32'h77);
    req_valid = '0;
    wait_idle(40, cyc);

    // Timeout: transmitter never responds
    stub_dead = 1'b1;
    req_valid = 2'b01; req_byte = 16'h0055;
    wait_accept(10, idx);
    req_valid = '0;
    n_en = 0;
    for (int c = 0; c < 20 && tx_en; c++) begin
      n_en++;
      tick();
    end
    check("timeout_en_cycles", 32'(n_en), 32'(BT));
    check("timeout_flag", 32'({timeout, busy, grant}), 32'({1'b1, 1'b0, 2'b00}));
    stub_dead = 1'b0;
    req_valid = 2'b10; req_byte = 16'h6600;
    wait_accept(10, idx);
    check("post_timeout_idx", 32'(idx), 32'd1);
    check("post_timeout_byte", 32'(tx_byte), 32'h66);
    req_valid = '0;
    wait_idle(40, cyc);
    check("timeout_sticky", 32'(timeout), 32'd1);

    // Reset in the middle of a frame
    req_valid = 2'b01; req_byte = 16'h0099;
    wait_accept(10, idx);
    req_valid = '0;
    tick(); tick(); tick(); tick();
    check("mid_frame_state", 32'({busy, tx_en}), 32'({1'b1, 1'b0}));
    #2 rst_ni = 1'b0;
    #1 check("async_reset", 32'({tx_en, tx_byte, grant, req_ready, busy, timeout}), 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    req_valid = 2'b11; req_byte = 16'h2010;
    wait_accept(10, idx);
    check("after_reset_idx", 32'(idx), 32'd0);
    req_valid = '0;
    wait_idle(40, cyc);

    // Randomized requesters and transmitter stalls, checked by the model
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req_ready[k]) begin
          req_valid[k] = 1'($urandom_range(0, 1));
          req_byte[8*k +: 8] = 8'($urandom);
        end else if (!req_valid[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[k] = 1'b1;
            req_byte[8*k +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
      force_busy = ($urandom_range(0, 7) == 0);
      tick();
    end
    req_valid = '0;
    force_busy = 1'b0;
    wait_idle(40, cyc);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
